// File: rtl/ifmap_pop_engine.sv
// Per-FIFO pop executor: latches a pop count per ifmap FIFO on its need_pop strobe,
// issues that many throttled single-cycle pops toward the PE row, then raises done.
module ifmap_pop_engine #(
   parameter int NUM_IFMAP_FIFO = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [31:0]                   ifmap_need_pop_i,
   input  logic [31:0][31:0]             ifmap_pop_num_i,
   input  logic [NUM_IFMAP_FIFO-1:0]     ifmap_fifo_empty_i,
   input  logic [NUM_IFMAP_FIFO-1:0]     pe_row_ready_i,
   output logic [NUM_IFMAP_FIFO-1:0]     ifmap_fifo_pop_o,
   output logic [31:0]                   ifmap_fifo_done_matrix_o,
   output logic                          busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      DONE = 2'd2
   } lane_state_e;

   lane_state_e                 state_q  [NUM_IFMAP_FIFO];
   lane_state_e                 state_d  [NUM_IFMAP_FIFO];
   logic [31:0]                 remain_q [NUM_IFMAP_FIFO];
   logic [31:0]                 remain_d [NUM_IFMAP_FIFO];
   logic [NUM_IFMAP_FIFO-1:0]   done_q;

   // A strobe outranks everything else in its cycle, so it also masks a pending pop
   // and the lane restarts cleanly from the new count.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      busy_o = 1'b0;
      for (int i = 0; i < NUM_IFMAP_FIFO; i++) begin
         state_d[i]  = state_q[i];
         remain_d[i] = remain_q[i];
         ifmap_fifo_pop_o[i] = (state_q[i] == POP) && !ifmap_fifo_empty_i[i] &&
                               pe_row_ready_i[i] && !ifmap_need_pop_i[i];
         busy_o = busy_o | (state_q[i] == POP);

         if (ifmap_need_pop_i[i]) begin
            if (ifmap_pop_num_i[i] != 32'd0) begin
               remain_d[i] = ifmap_pop_num_i[i];
               state_d[i]  = POP;
            end else begin
               remain_d[i] = 32'd0;
               state_d[i]  = DONE;
            end
         end else if (ifmap_fifo_pop_o[i]) begin
            // remain is never zero in POP, so this cannot underflow
            remain_d[i] = remain_q[i] - 32'd1;
            if (remain_q[i] == 32'd1) begin
               state_d[i] = DONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_IFMAP_FIFO; i++) begin
            state_q[i]  <= IDLE;
            remain_q[i] <= 32'd0;
         end
         done_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all lanes update
         // from the same pre-edge values.
         for (int i = 0; i < NUM_IFMAP_FIFO; i++) begin
            state_q[i]  <= state_d[i];
            remain_q[i] <= remain_d[i];
            done_q[i]   <= (state_d[i] == DONE);
         end
      end
   end

   // Unserved lanes read as done so the consumer's AND-reduction still passes.
   for (genvar g = 0; g < 32; g++) begin : g_done
      if (g < NUM_IFMAP_FIFO) begin : g_lane
         assign ifmap_fifo_done_matrix_o[g] = done_q[g];
      end else begin : g_tie
         assign ifmap_fifo_done_matrix_o[g] = 1'b1;
      end
   end

   if (NUM_IFMAP_FIFO < 32) begin : g_unused
      logic unused_hi_bits;
      assign unused_hi_bits = ^{ifmap_need_pop_i[31:NUM_IFMAP_FIFO],
                                ifmap_pop_num_i[31:NUM_IFMAP_FIFO]};
   end

endmodule

// File: tb/tb_ifmap_pop_engine.sv
// Self-checking bench for ifmap_pop_engine: constant vector table, directed
// preheat/stall/restart/reset sequences, and random traffic against a lane model.
module tb_ifmap_pop_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0]       need;
   logic [31:0][31:0] num;
   logic [31:0]       empty;
   logic [31:0]       ready;

   logic [31:0] pop;
   logic [31:0] done;
   logic        busy;
   logic [29:0] pop30;
   logic [31:0] done30;
   logic        busy30;

   ifmap_pop_engine #(.NUM_IFMAP_FIFO(32)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .ifmap_need_pop_i         (need),
      .ifmap_pop_num_i          (num),
      .ifmap_fifo_empty_i       (empty),
      .pe_row_ready_i           (ready),
      .ifmap_fifo_pop_o         (pop),
      .ifmap_fifo_done_matrix_o (done),
      .busy_o                   (busy)
   );

   ifmap_pop_engine #(.NUM_IFMAP_FIFO(30)) dut30 (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .ifmap_need_pop_i         (need),
      .ifmap_pop_num_i          (num),
      .ifmap_fifo_empty_i       (empty[29:0]),
      .pe_row_ready_i           (ready[29:0]),
      .ifmap_fifo_pop_o         (pop30),
      .ifmap_fifo_done_matrix_o (done30),
      .busy_o                   (busy30)
   );

   int checks = 0;
   int errors = 0;

   // Lane model: pending pop count, whether a count is being worked off, and done flag.
   logic [31:0] m_rem  [32];
   bit          m_act  [32];
   bit          m_done [32];
   int          pop_cnt[32];

   typedef struct {
      bit       need0;
      bit [7:0] num0;
      bit       empty0;
      bit       ready0;
      bit       exp_pop0;
      bit       exp_done0;
      bit       exp_busy;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_pop();
      logic [31:0] p;
      for (int i = 0; i < 32; i++)
         p[i] = m_act[i] && !empty[i] && ready[i] && !need[i];
      return p;
   endfunction

   function automatic logic [31:0] model_done();
      logic [31:0] d;
      for (int i = 0; i < 32; i++) d[i] = m_done[i];
      return d;
   endfunction

   function automatic logic model_busy(input int lanes);
      logic b = 1'b0;
      for (int i = 0; i < lanes; i++) b = b | m_act[i];
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_rem[i] = 0; m_act[i] = 0; m_done[i] = 0;
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 32; i++) pop_cnt[i] = 0;
   endtask

   // Called away from the edge: compare both DUTs with the model for this cycle.
   task automatic compare_model();
      logic [31:0] ep;
      logic [31:0] ed;
      ep = model_pop();
      ed = model_done();
      check("pop", pop, ep);
      check("done", done, ed);
      check("busy", busy, model_busy(32));
      check("pop30", {2'b00, pop30}, {2'b00, ep[29:0]});
      check("done30", done30, {2'b11, ed[29:0]});
      check("busy30", busy30, model_busy(30));
      for (int i = 0; i < 32; i++) pop_cnt[i] += int'(pop[i]);
   endtask

   // Apply the current inputs to the model, then move to just after the next edge.
   task automatic advance();
      logic [31:0] ep;
      ep = model_pop();
      for (int i = 0; i < 32; i++) begin
         if (need[i]) begin
            if (num[i] != 0) begin
               m_act[i] = 1; m_rem[i] = num[i]; m_done[i] = 0;
            end else begin
               m_act[i] = 0; m_rem[i] = 0; m_done[i] = 1;
            end
         end else if (ep[i]) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin
               m_act[i] = 0; m_done[i] = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      compare_model();
      advance();
   endtask

   vec_t vecs[13];
   int   ok_lanes;

   initial begin
      // lane 0 only: count 2, count 0 while done, stall, restart, restart with 0
      vecs[0]  = '{1, 2, 0, 1, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 1, 1, 0, 1};
      vecs[2]  = '{0, 0, 0, 1, 1, 0, 1};
      vecs[3]  = '{0, 0, 0, 1, 0, 1, 0};
      vecs[4]  = '{1, 0, 0, 1, 0, 1, 0};
      vecs[5]  = '{0, 0, 0, 1, 0, 1, 0};
      vecs[6]  = '{1, 1, 1, 1, 0, 1, 0};
      vecs[7]  = '{0, 0, 1, 1, 0, 0, 1};
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 1};
      vecs[9]  = '{1, 3, 0, 1, 0, 0, 1};
      vecs[10] = '{0, 0, 0, 1, 1, 0, 1};
      vecs[11] = '{1, 0, 0, 1, 0, 0, 1};
      vecs[12] = '{0, 0, 0, 1, 0, 1, 0};

      rst_n = 1'b0;
      need  = '0;
      num   = '0;
      empty = '0;
      ready = '1;
      model_reset();
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pop", pop, 32'h0);
      check("rst_done", done, 32'h0);
      check("rst_busy", busy, 32'h0);
      check("rst_done30", done30, 32'hC000_0000);
      check("rst_pop30", {2'b00, pop30}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // constant vector table on lane 0
      for (int v = 0; v < 13; v++) begin
         need[0]  = vecs[v].need0;
         num[0]   = {24'd0, vecs[v].num0};
         empty[0] = vecs[v].empty0;
         ready[0] = vecs[v].ready0;
         @(negedge clk);
         check($sformatf("vec%0d_pop", v), pop[0], vecs[v].exp_pop0);
         check($sformatf("vec%0d_done", v), done[0], vecs[v].exp_done0);
         check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
         compare_model();
         advance();
      end
      need = '0; empty = '0; ready = '1;
      step();

      // pointwise preheat: every lane count 1
      clear_counts();
      need = '1;
      for (int i = 0; i < 32; i++) num[i] = 32'd1;
      step();
      need = '0;
      @(negedge clk);
      check("pointwise_pop_n1", pop, 32'hFFFF_FFFF);
      compare_model();
      advance();
      @(negedge clk);
      check("pointwise_done_n2", done, 32'hFFFF_FFFF);
      check("pointwise_pop_n2", pop, 32'h0);
      compare_model();
      advance();
      ok_lanes = 0;
      for (int i = 0; i < 32; i++) if (pop_cnt[i] == 1) ok_lanes++;
      check("pointwise_lanes_one_pop", ok_lanes, 32);

      // depthwise: counts 3,3,3,6,...,30 for lanes 0..29, zero for lanes 30-31
      clear_counts();
      need = '1;
      for (int i = 0; i < 32; i++) num[i] = (i < 30) ? 32'(3 * (i / 3 + 1)) : 32'd0;
      step();
      need = '0;
      @(negedge clk);
      check("depth_done_hi_n1", done[31:30], 2'b11);
      compare_model();
      advance();
      for (int c = 2; c <= 30; c++) step();
      @(negedge clk);
      check("depth_done_n31", done, 32'hFFFF_FFFF);
      compare_model();
      advance();
      for (int i = 0; i < 30; i++)
         check($sformatf("depth_cnt%0d", i), pop_cnt[i], 32'(3 * (i / 3 + 1)));

      // stalls on lane 5: two empty cycles, one not-ready cycle
      clear_counts();
      need[5] = 1'b1; num[5] = 32'd4;
      step();
      need[5] = 1'b0; empty[5] = 1'b1;
      step();
      step();
      empty[5] = 1'b0; ready[5] = 1'b0;
      step();
      ready[5] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check("stall_not_done_early", done[5], 1'b0);
         step();
      end
      check("stall_done_n8", done[5], 1'b1);
      check("stall_pop_count", pop_cnt[5], 4);
      step();

      // restart on lane 2: count 6, new strobe with count 2 after 3 pops
      clear_counts();
      need[2] = 1'b1; num[2] = 32'd6;
      step();
      need[2] = 1'b0;
      repeat (3) step();
      need[2] = 1'b1; num[2] = 32'd2;
      @(negedge clk);
      check("restart_no_pop_strobe", pop[2], 1'b0);
      compare_model();
      advance();
      need[2] = 1'b0;
      repeat (2) step();
      check("restart_done", done[2], 1'b1);
      check("restart_pop_count", pop_cnt[2], 5);
      step();

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 32; i++) begin
            need[i]  = ($urandom_range(0, 11) == 0);
            num[i]   = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
            empty[i] = ($urandom_range(0, 3) == 0);
            ready[i] = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      // drain, then reset in the middle of a count
      need = '0; empty = '0; ready = '1;
      repeat (10) step();
      need[0] = 1'b1; num[0] = 32'd10;
      step();
      need[0] = 1'b0;
      repeat (3) step();
      #2;
      check("pre_reset_pop", pop[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_pop", pop, 32'h0);
      check("async_rst_done", done, 32'h0);
      check("async_rst_busy", busy, 32'h0);
      check("async_rst_done30", done30, 32'hC000_0000);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clear_counts();
      repeat (6) step();
      check("post_reset_no_pops", pop_cnt[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifmap_pop_engine.md
# ifmap_pop_engine

Per-FIFO pop executor, the responder side of the preheat handshake. It latches a pop count per ifmap FIFO when that FIFO's `need_pop` bit is asserted. It then issues exactly that many single-cycle pops from the FIFO toward its PE row, throttled by FIFO-empty and PE-row-ready. It reports completion per FIFO on a done matrix, which the preheat controller AND-reduces before leaving its wait state.

## Interface
- `NUM_IFMAP_FIFO`, 32: number of ifmap FIFOs / PE rows served; legal range 1..32.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ifmap_need_pop_i`  in  32  per-FIFO start strobe. It is sampled every cycle; bit i starts FIFO i.
- `ifmap_pop_num_i`  in  32 x [31:0]  per-FIFO pop count. Valid only in cycles where the matching `need_pop` bit is 1.
- `ifmap_fifo_empty_i`  in  `NUM_IFMAP_FIFO`  FIFO i is empty.
- `pe_row_ready_i`  in  `NUM_IFMAP_FIFO`  PE row i accepts one datum this cycle.
- `ifmap_fifo_pop_o`  out  `NUM_IFMAP_FIFO`  pop strobe to FIFO i; also the data-valid for PE row i.
- `ifmap_fifo_done_matrix_o`  out  32  per-FIFO done flag, registered.
- `busy_o`  out  1  OR of all lanes in state POP.

## Operation
- The block has `NUM_IFMAP_FIFO` identical, independent lanes. Each lane holds:
  - a 2-bit state: IDLE, POP or DONE;
  - a 32-bit `remain` counter.
- Lane i transitions:
  - Any state, with `need_pop_i[i]`=1 and `pop_num_i[i]`!=0: load `remain`=`pop_num_i[i]`, next state POP.
  - Any state, with `need_pop_i[i]`=1 and `pop_num_i[i]`==0: next state DONE.
  - In POP, when a pop fires and `remain`==1: next state DONE.
  - DONE holds until the next `need_pop_i[i]`. There is no timeout or auto-return to IDLE.
- `need_pop_i[i]` has priority over every other event in the same cycle, including a pending pop. A strobe arriving while the lane is in POP aborts the old count without firing its pop that cycle and reloads the new count (restart semantics).
- Pop condition for lane i: state==POP AND !`empty[i]` AND `ready[i]` AND !`need_pop_i[i]`.
  - `pop_o[i]` is combinational from this condition.
  - Each pop decrements `remain` by 1. `remain` never underflows.
- While empty or not-ready, the lane stalls in POP with no pop and no decrement. Stalls are unbounded.
- `done_matrix_o[i]` = (lane state==DONE), registered.
- Bits i >= `NUM_IFMAP_FIFO`:
  - `done_matrix_o[i]` is tied to 1 so that the consumer's AND-reduction passes.
  - The matching `need_pop`/`pop_num` bits are ignored.
- Only the 32-bit value of `pop_num` is used; there is no saturation or width extension.

## Timing
- Reset values: all lanes IDLE, `remain`=0, `pop_o`=0, `busy_o`=0.
  - `done_matrix_o` = 0 for bits below `NUM_IFMAP_FIFO` and 1 for the bits above.
- Reset is asynchronous. Asserting it mid-operation returns every lane to IDLE immediately: `pop_o` drops in the same cycle and `done` clears. No partial-count state survives.
- Strobe cycle N, count k>0, no stalls:
  - `pop_o` high in cycles N+1 .. N+k;
  - `done` high from N+k+1.
- Strobe cycle N, count 0: `done` high from N+1 and no pops.
- Strobe cycle N while the lane is in DONE: `done` low from N+1 (next state POP), or stays high if the count is 0.
- Each stall cycle adds exactly one cycle to the completion time.
- At most one pop per lane per cycle. Lanes never couple; all lanes may pop in the same cycle.
- `busy_o` is registered-state derived: it is high in any cycle in which some lane's state is POP.

## Test plan
- Pointwise preheat: all 32 `need_pop` bits=1 and all counts=1 at cycle N, FIFOs non-empty, all ready -> every `pop_o` high only at N+1; `done_matrix_o`=32'hFFFF_FFFF from N+2.
- Depthwise pattern: counts 3,3,3,6,...,30,30,30 for lanes 0..29 and 0 for lanes 30-31 -> lane i pops exactly 3*(i/3+1) times; lanes 30-31 are done at N+1; the full matrix is all ones at N+31.
- Stalls: lane 5 with count 4; `empty[5]` high for 2 cycles, then `ready[5]` low for 1 cycle -> exactly 4 pops, none during stall cycles; `done[5]` high at N+8.
- Restart: lane 2 gets count 6, then a new strobe with count 2 after 3 pops -> no pop in the strobe cycle; exactly 2 further pops; done follows; total 5 pops.
- `NUM_IFMAP_FIFO`=30: strobe all lanes -> bits 30-31 of `done_matrix_o` read 1 from reset onward; `pop_o` is 30 bits wide.
- Reset mid-operation: `rst_n` low during POP with `remain`=7 -> `pop_o`=0 immediately; after release, lanes are IDLE, done bits are 0, and no pops occur until a new strobe.
